// File: rtl/dmem_access_ctrl.sv
// Load/store access controller between the CPU memory stage and a byte-addressed data memory.
// Optional range checking is enabled by defining DMEM_ACC_RANGE_CHECK_EN.
module dmem_access_ctrl #(
    parameter int          ADDR_W    = 11,
    parameter int          MEM_BYTES = 1024,
    parameter logic [31:0] BASE      = 32'h1001_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [2:0]        op,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              addr_err,
    output logic              dm_cs,
    output logic              dm_r,
    output logic              dm_w_w,
    output logic              dm_w_h,
    output logic              dm_w_b,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    input  logic [31:0]       dm_rdata,
    output logic [1:0]        dbg_state
);

    // Handshake: req is sampled on a rising edge only while the FSM is IDLE
    // (busy low); done pulses for one cycle and addr_err is valid only with done.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    state_t      state, state_nxt;
    logic [2:0]  op_q;
    logic [31:0] offset;
    logic [2:0]  acc_size;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic        accept;
    logic        issue_go;
    logic        is_load;
    logic [31:0] load_ext;

    assign offset    = addr - BASE;
    assign is_load   = (op != OP_SW) && (op != OP_SH) && (op != OP_SB);
    assign dbg_state = state;

    always_comb begin
        misaligned = 1'b0;
        acc_size   = 3'd1;
        case (op)
            OP_LW, OP_SW: begin
                misaligned = |addr[1:0];
                acc_size   = 3'd4;
            end
            OP_LH, OP_LHU, OP_SH: begin
                misaligned = addr[0];
                acc_size   = 3'd2;
            end
            default: begin
                misaligned = 1'b0;
                acc_size   = 3'd1;
            end
        endcase
    end

`ifdef DMEM_ACC_RANGE_CHECK_EN
    // 33-bit end offset so an access near the top of the address space cannot wrap.
    logic [32:0] end_off;
    assign end_off      = {1'b0, offset} + {30'd0, acc_size};
    assign out_of_range = (addr < BASE) || (end_off > 33'(MEM_BYTES));
`else
    // Without the check the offset simply wraps to ADDR_W bits.
    logic unused_range_bits;
    assign unused_range_bits = ^{offset[31:ADDR_W], acc_size, 32'(MEM_BYTES)};
    assign out_of_range      = 1'b0;
`endif

    assign req_err  = misaligned || out_of_range;
    assign accept   = (state == IDLE) && req;
    assign issue_go = accept && !req_err;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = req_err ? DONE : ISSUE;
            ISSUE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load_ext = dm_rdata;
        case (op_q)
            OP_LH:   load_ext = {{16{dm_rdata[15]}}, dm_rdata[15:0]};
            OP_LHU:  load_ext = {16'd0, dm_rdata[15:0]};
            OP_LB:   load_ext = {{24{dm_rdata[7]}}, dm_rdata[7:0]};
            OP_LBU:  load_ext = {24'd0, dm_rdata[7:0]};
            default: load_ext = dm_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_q  <= OP_LW;
        end else begin
            state <= state_nxt;
            if (accept) op_q <= op;
        end
    end

    // Every interface output is a flop loaded from the next-state decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            addr_err <= 1'b0;
            rdata    <= 32'd0;
            dm_cs    <= 1'b0;
            dm_r     <= 1'b0;
            dm_w_w   <= 1'b0;
            dm_w_h   <= 1'b0;
            dm_w_b   <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= 32'd0;
        end else begin
            busy     <= (state_nxt != IDLE);
            done     <= (state_nxt == DONE);
            addr_err <= accept && req_err;
            dm_cs    <= issue_go;
            dm_r     <= issue_go && is_load;
            dm_w_w   <= issue_go && (op == OP_SW);
            dm_w_h   <= issue_go && (op == OP_SH);
            dm_w_b   <= issue_go && (op == OP_SB);
            dm_addr  <= issue_go ? offset[ADDR_W-1:0] : '0;
            dm_wdata <= issue_go ? wdata : 32'd0;
            if (state == ISSUE && dm_r) rdata <= load_ext;
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed self-checking bench for dmem_access_ctrl with a byte-array data memory model.
module tb_dmem_access_ctrl;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    logic        clk, rst, req;
    logic [2:0]  op;
    logic [31:0] addr, wdata;
    logic        busy, done, addr_err;
    logic [31:0] rdata;
    logic        dm_cs, dm_r, dm_w_w, dm_w_h, dm_w_b;
    logic [10:0] dm_addr;
    logic [31:0] dm_wdata, dm_rdata;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    dmem_access_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .addr_err(addr_err),
        .dm_cs(dm_cs), .dm_r(dm_r), .dm_w_w(dm_w_w), .dm_w_h(dm_w_h), .dm_w_b(dm_w_b),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // data memory responder, little-endian, wraps at 1 KiB
    logic [7:0] mem [0:1023];
    logic [9:0] ix;
    assign ix = dm_addr[9:0];
    assign dm_rdata = (dm_cs && dm_r) ? {mem[ix + 10'd3], mem[ix + 10'd2], mem[ix + 10'd1], mem[ix]}
                                      : 32'hzzzz_zzzz;

    always @(posedge clk) begin
        if (dm_cs && dm_w_w) begin
            mem[ix]         <= dm_wdata[7:0];
            mem[ix + 10'd1] <= dm_wdata[15:8];
            mem[ix + 10'd2] <= dm_wdata[23:16];
            mem[ix + 10'd3] <= dm_wdata[31:24];
        end else if (dm_cs && dm_w_h) begin
            mem[ix]         <= dm_wdata[7:0];
            mem[ix + 10'd1] <= dm_wdata[15:8];
        end else if (dm_cs && dm_w_b) begin
            mem[ix]         <= dm_wdata[7:0];
        end
    end

    // driver: one request, then observe six cycles (c=1 is the cycle after the sampling edge)
    task automatic run_access(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                              output int done_lat, output logic err, output logic [31:0] rd,
                              output int cs_cyc, output int r_cyc, output int w_cyc,
                              output logic [2:0] wkind, output logic [10:0] cs_addr);
        @(negedge clk);
        req = 1'b1; op = o; addr = a; wdata = wd;
        @(posedge clk);
        #1 req = 1'b0;
        done_lat = -1; err = 1'b0; cs_cyc = 0; r_cyc = 0; w_cyc = 0; wkind = 3'b000; cs_addr = '0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (dm_cs) begin cs_cyc++; cs_addr = dm_addr; end
            if (dm_r) r_cyc++;
            if (dm_w_w || dm_w_h || dm_w_b) w_cyc++;
            wkind = wkind | {dm_w_w, dm_w_h, dm_w_b};
            if (done && done_lat < 0) begin done_lat = c; err = addr_err; end
        end
        rd = rdata;
    endtask

    int          lat, csn, rn, wn;
    logic        er;
    logic [31:0] rd;
    logic [2:0]  wk;
    logic [10:0] ca;

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; op = 3'b000; addr = 32'd0; wdata = 32'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, addr_err, dm_cs, dm_r, dm_w_w, dm_w_h, dm_w_b} !== 8'd0) begin
            errors++; $display("FAIL reset_flags got=%b exp=00000000",
                {busy, done, addr_err, dm_cs, dm_r, dm_w_w, dm_w_h, dm_w_b});
        end
        checks++;
        if (rdata !== 32'd0 || dm_addr !== 11'd0 || dm_wdata !== 32'd0) begin
            errors++; $display("FAIL reset_data rdata=%h dm_addr=%h dm_wdata=%h exp=0", rdata, dm_addr, dm_wdata);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_release busy=%b done=%b exp=0", busy, done);
        end
    endtask

    task automatic test_word();
        run_access(OP_SW, 32'h1001_0004, 32'hDEAD_BEEF, lat, er, rd, csn, rn, wn, wk, ca);
        checks++;
        if (wn !== 1 || wk !== 3'b100 || ca !== 11'd4) begin
            errors++; $display("FAIL sw_strobe w_cycles=%0d kind=%b addr=%h exp=1 100 004", wn, wk, ca);
        end
        checks++;
        if (lat !== 2 || er !== 1'b0 || rn !== 0) begin
            errors++; $display("FAIL sw_done lat=%0d err=%b r=%0d exp=2 0 0", lat, er, rn);
        end
        run_access(OP_LW, 32'h1001_0004, 32'd0, lat, er, rd, csn, rn, wn, wk, ca);
        checks++;
        if (rd !== 32'hDEAD_BEEF || lat !== 2 || er !== 1'b0) begin
            errors++; $display("FAIL lw_data rdata=%h lat=%0d err=%b exp=deadbeef 2 0", rd, lat, er);
        end
        checks++;
        if (rn !== 1 || wn !== 0 || csn !== 1) begin
            errors++; $display("FAIL lw_strobe r=%0d w=%0d cs=%0d exp=1 0 1", rn, wn, csn);
        end
    endtask

    task automatic test_byte();
        run_access(OP_LB, 32'h1001_0007, 32'd0, lat, er, rd, csn, rn, wn, wk, ca);
        checks++;
        if (rd !== 32'hFFFF_FFDE || ca !== 11'd7) begin
            errors++; $display("FAIL lb_sext rdata=%h addr=%h exp=ffffffde 007", rd, ca);
        end
        run_access(OP_LBU, 32'h1001_0007, 32'd0, lat, er, rd, csn, rn, wn, wk, ca);
        checks++;
        if (rd !== 32'h0000_00DE) begin
            errors++; $display("FAIL lbu_zext rdata=%h exp=000000de", rd);
        end
        run_access(OP_SB, 32'h1001_0005, 32'h1234_5677, lat, er, rd, csn, rn, wn, wk, ca);
        checks++;
        if (wk !== 3'b001 || wn !== 1 || er !== 1'b0) begin
            errors++; $display("FAIL sb_strobe kind=%b w=%0d err=%b exp=001 1 0", wk, wn, er);
        end
        run_access(OP_LW, 32'h1001_0004, 32'd0, lat, er, rd, csn, rn, wn, wk, ca);
        checks++;
        if (rd !== 32'hDEAD_77EF) begin
            errors++; $display("FAIL sb_merge rdata=%h exp=dead77ef", rd);
        end
    endtask

    task automatic test_half();
        run_access(OP_SW, 32'h1001_0010, 32'hA5A5_A5A5, lat, er, rd, csn, rn, wn, wk, ca);
        run_access(OP_SH, 32'h1001_0010, 32'h0000_8001, lat, er, rd, csn, rn, wn, wk, ca);
        checks++;
        if (wk !== 3'b010 || wn !== 1 || ca !== 11'h010) begin
            errors++; $display("FAIL sh_strobe kind=%b w=%0d addr=%h exp=010 1 010", wk, wn, ca);
        end
        run_access(OP_LH, 32'h1001_0010, 32'd0, lat, er, rd, csn, rn, wn, wk, ca);
        checks++;
        if (rd !== 32'hFFFF_8001) begin
            errors++; $display("FAIL lh_sext rdata=%h exp=ffff8001", rd);
        end
        run_access(OP_LHU, 32'h1001_0010, 32'd0, lat, er, rd, csn, rn, wn, wk, ca);
        checks++;
        if (rd !== 32'h0000_8001) begin
            errors++; $display("FAIL lhu_zext rdata=%h exp=00008001", rd);
        end
        run_access(OP_LBU, 32'h1001_0012, 32'd0, lat, er, rd, csn, rn, wn, wk, ca);
        checks++;
        if (rd !== 32'h0000_00A5) begin
            errors++; $display("FAIL sh_keep_byte12 rdata=%h exp=000000a5", rd);
        end
    endtask

    task automatic test_misaligned();
        run_access(OP_LW, 32'h1001_0002, 32'd0, lat, er, rd, csn, rn, wn, wk, ca);
        checks++;
        if (lat !== 1 || er !== 1'b1) begin
            errors++; $display("FAIL lw_misaligned lat=%0d err=%b exp=1 1", lat, er);
        end
        checks++;
        if (csn !== 0 || rd !== 32'h0000_00A5) begin
            errors++; $display("FAIL lw_misaligned_side cs=%0d rdata=%h exp=0 000000a5", csn, rd);
        end
        run_access(OP_SH, 32'h1001_0011, 32'hFFFF_FFFF, lat, er, rd, csn, rn, wn, wk, ca);
        checks++;
        if (lat !== 1 || er !== 1'b1 || csn !== 0) begin
            errors++; $display("FAIL sh_misaligned lat=%0d err=%b cs=%0d exp=1 1 0", lat, er, csn);
        end
        run_access(OP_LB, 32'h1001_0013, 32'd0, lat, er, rd, csn, rn, wn, wk, ca);
        checks++;
        if (er !== 1'b0 || lat !== 2 || rd !== 32'hFFFF_FFA5) begin
            errors++; $display("FAIL lb_odd lat=%0d err=%b rdata=%h exp=2 0 ffffffa5", lat, er, rd);
        end
    endtask

    task automatic test_range();
`ifdef DMEM_ACC_RANGE_CHECK_EN
        run_access(OP_LW, 32'h1001_03FC, 32'd0, lat, er, rd, csn, rn, wn, wk, ca);
        checks++;
        if (er !== 1'b0 || lat !== 2 || ca !== 11'h3FC) begin
            errors++; $display("FAIL range_top_ok lat=%0d err=%b addr=%h exp=2 0 3fc", lat, er, ca);
        end
        run_access(OP_LW, 32'h1001_0400, 32'd0, lat, er, rd, csn, rn, wn, wk, ca);
        checks++;
        if (er !== 1'b1 || lat !== 1 || csn !== 0) begin
            errors++; $display("FAIL range_above lat=%0d err=%b cs=%0d exp=1 1 0", lat, er, csn);
        end
        run_access(OP_LB, 32'h1000_FFFF, 32'd0, lat, er, rd, csn, rn, wn, wk, ca);
        checks++;
        if (er !== 1'b1 || lat !== 1 || csn !== 0) begin
            errors++; $display("FAIL range_below lat=%0d err=%b cs=%0d exp=1 1 0", lat, er, csn);
        end
`else
        run_access(OP_LW, 32'h1001_0400, 32'd0, lat, er, rd, csn, rn, wn, wk, ca);
        checks++;
        if (er !== 1'b0 || lat !== 2 || ca !== 11'h400) begin
            errors++; $display("FAIL wrap_400 lat=%0d err=%b addr=%h exp=2 0 400", lat, er, ca);
        end
        run_access(OP_LB, 32'h1000_FFFF, 32'd0, lat, er, rd, csn, rn, wn, wk, ca);
        checks++;
        if (er !== 1'b0 || lat !== 2 || ca !== 11'h7FF) begin
            errors++; $display("FAIL wrap_below lat=%0d err=%b addr=%h exp=2 0 7ff", lat, er, ca);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int done_seen;
        @(negedge clk);
        req = 1'b1; op = OP_SW; addr = 32'h1001_0004; wdata = 32'h1234_5678;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        checks++;
        if (dm_w_w !== 1'b1 || dm_cs !== 1'b1) begin
            errors++; $display("FAIL mid_issue dm_w_w=%b dm_cs=%b exp=1 1", dm_w_w, dm_cs);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, addr_err, dm_cs, dm_r, dm_w_w, dm_w_h, dm_w_b} !== 8'd0 ||
            rdata !== 32'd0 || dm_addr !== 11'd0 || dm_wdata !== 32'd0) begin
            errors++; $display("FAIL mid_reset_outputs flags=%b rdata=%h dm_addr=%h exp=0",
                {busy, done, addr_err, dm_cs, dm_r, dm_w_w, dm_w_h, dm_w_b}, rdata, dm_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            errors++; $display("FAIL mid_reset_done done_cycles=%0d exp=0", done_seen);
        end
        run_access(OP_LW, 32'h1001_0004, 32'd0, lat, er, rd, csn, rn, wn, wk, ca);
        checks++;
        if (rd !== 32'hDEAD_77EF) begin
            errors++; $display("FAIL mid_reset_no_commit rdata=%h exp=dead77ef", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] cs_m, done_m, busy_m;
        cs_m = 8'd0; done_m = 8'd0; busy_m = 8'd0;
        @(negedge clk);
        req = 1'b1; op = OP_LBU; addr = 32'h1001_0007; wdata = 32'd0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            cs_m[c] = dm_cs; done_m[c] = done; busy_m[c] = busy;
        end
        req = 1'b0;
        checks++;
        if (cs_m !== 8'b1001_0010) begin
            errors++; $display("FAIL held_req_cs got=%b exp=10010010", cs_m);
        end
        checks++;
        if (done_m !== 8'b0010_0100 || busy_m !== 8'b1011_0110) begin
            errors++; $display("FAIL held_req_done done=%b busy=%b exp=00100100 10110110", done_m, busy_m);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (rdata !== 32'h0000_00DE || busy !== 1'b0) begin
            errors++; $display("FAIL held_req_end rdata=%h busy=%b exp=000000de 0", rdata, busy);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misaligned();
        test_range();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
